// File: rtl/seq_scan_ctrl_pkg.sv
// Shared definitions for the serial scan controller.
//   state_t  : controller FSM states
//   N_DEF    : default pattern / shift-register width
//   CW_DEF   : default width of length, count and index fields
//   result_t : result record returned at the end of a scan job
package seq_scan_ctrl_pkg;

  localparam int unsigned N_DEF  = 4;
  localparam int unsigned CW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SCAN,
    REPORT
  } state_t;

  typedef struct packed {
    logic [CW_DEF-1:0] match_cnt;
    logic [CW_DEF-1:0] first_idx;
    logic              found;
  } result_t;

endpackage

// File: rtl/seq_scan_ctrl_shift_match.sv
// N-bit serial shift register with pattern comparator.
//   clk, rst  : clock, synchronous active-high reset (clears contents)
//   load      : take seed this cycle (has priority over shift_en)
//   seed      : value loaded on load
//   shift_en  : shift bit_in into bit 0 this cycle
//   bit_in    : serial input, becomes the newest bit (data[0])
//   code      : pattern to compare against
//   hit       : shift_en and the post-shift value equals code
module shift_match #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] seed,
  input  logic         shift_en,
  input  logic         bit_in,
  input  logic [N-1:0] code,
  output logic         hit
);

  logic [N-1:0] data;
  logic [N-1:0] data_next;

  assign data_next = {data[N-2:0], bit_in};

  // Hit is judged on the value the register is about to take, so the
  // bit that completes a match is counted in the same cycle it arrives.
  // A freshly loaded seed is never compared.
  assign hit = shift_en && !load && (data_next == code);

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= seed;
    end else if (shift_en) begin
      data <= data_next;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Scan-job sequencer: accepts a job (code, seed, len), loads the shift
// register, streams exactly len serial bits through it while counting
// pattern hits, then presents a result record until the host takes it.
//   clk, rst                         : clock, synchronous active-high reset
//   cmd_valid/cmd_ready              : job command handshake
//   cmd_code, cmd_seed, cmd_len      : pattern, initial contents, bit count
//   bit_valid/bit_ready, bit_in      : serial bit handshake
//   done_valid/done_ready            : result handshake
//   match_cnt, first_idx, found      : result record
//   busy                             : state is not IDLE
module seq_scan_ctrl
  import seq_scan_ctrl_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [N-1:0]  cmd_code,
  input  logic [N-1:0]  cmd_seed,
  input  logic [CW-1:0] cmd_len,
  input  logic          bit_valid,
  output logic          bit_ready,
  input  logic          bit_in,
  output logic          done_valid,
  input  logic          done_ready,
  output logic [CW-1:0] match_cnt,
  output logic [CW-1:0] first_idx,
  output logic          found,
  output logic          busy
);

  state_t        state;
  logic [N-1:0]  code_q;
  logic [N-1:0]  seed_q;
  logic [CW-1:0] len_q;
  logic [CW-1:0] consumed;
  logic          load;
  logic          shift_en;
  logic          hit;

  // Handshake outputs come from the state register alone.
  assign cmd_ready  = (state == IDLE);
  assign bit_ready  = (state == SCAN);
  assign done_valid = (state == REPORT);
  assign busy       = (state != IDLE);

  assign load     = (state == LOAD);
  assign shift_en = (state == SCAN) && bit_valid;

  shift_match #(
    .N (N)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .seed     (seed_q),
    .shift_en (shift_en),
    .bit_in   (bit_in),
    .code     (code_q),
    .hit      (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      code_q    <= '0;
      seed_q    <= '0;
      len_q     <= '0;
      consumed  <= '0;
      match_cnt <= '0;
      first_idx <= '0;
      found     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            code_q    <= cmd_code;
            seed_q    <= cmd_seed;
            len_q     <= cmd_len;
            consumed  <= '0;
            match_cnt <= '0;
            first_idx <= '0;
            found     <= 1'b0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          state <= (len_q == '0) ? REPORT : SCAN;
        end
        SCAN: begin
          if (bit_valid) begin
            consumed <= consumed + CW'(1);
            if (hit) begin
              match_cnt <= match_cnt + CW'(1);
              if (!found) begin
                first_idx <= consumed;
                found     <= 1'b1;
              end
            end
            if (consumed == len_q - CW'(1)) begin
              state <= REPORT;
            end
          end
        end
        REPORT: begin
          if (done_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
